// File: rtl/demux_scan_sequencer_if.sv
// Handshake/data bundle between a scan controller and demux_scan_sequencer.
// Purely combinational wiring; no latency of its own.
// No backpressure: every request is sampled once per clock by the sequencer.
// Signals: start/stop/cont/ch_mask/din are requests into the sequencer;
//          s1/s0/y/busy/frame_done/err are the sequencer's registered outputs.
interface demux_scan_sequencer_if;
    logic       start;
    logic       stop;
    logic       cont;
    logic [3:0] ch_mask;
    logic       din;
    logic       s0;
    logic       s1;
    logic       y;
    logic       busy;
    logic       frame_done;
    logic       err;

    // Controller side: drives requests, observes the demux controls.
    modport master (
        output start, stop, cont, ch_mask, din,
        input  s0, s1, y, busy, frame_done, err
    );

    // Sequencer side.
    modport slave (
        input  start, stop, cont, ch_mask, din,
        output s0, s1, y, busy, frame_done, err
    );
endinterface

// File: rtl/demux_scan_sequencer.sv
// Round-robin scan of the enabled 1:4 demux channels, DWELL cycles per channel, din gated onto y.
// Latency: select/busy one cycle after start; y(t+1) = din(t) while scanning.
// No backpressure: start is dropped outside IDLE, stop takes effect at the next frame boundary.
// Ports: clk_i, rst_i (sync, active-high); bus (slave modport) carries
//        start/stop/cont/ch_mask/din in and s1/s0/y/busy/frame_done/err out, all outputs registered.
module demux_scan_sequencer #(
    parameter int DWELL = 4,
    parameter int CNT_W = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    demux_scan_sequencer_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DWELL - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       sel_q, sel_d;
    logic [3:0]       mask_q, mask_d;
    logic             stop_pend_q, stop_pend_d;
    logic             y_q, y_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    // Lowest enabled channel of a mask (0 when the mask is empty).
    function automatic logic [1:0] lowest_ch(input logic [3:0] m);
        lowest_ch = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) lowest_ch = 2'(i);
        end
    endfunction

    // True when some enabled channel sits above ch.
    function automatic logic has_above(input logic [3:0] m, input logic [1:0] ch);
        has_above = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (m[i] && (i > int'(ch))) has_above = 1'b1;
        end
    endfunction

    // Next enabled channel above ch; only meaningful when has_above() is true.
    function automatic logic [1:0] next_above(input logic [3:0] m, input logic [1:0] ch);
        next_above = ch;
        for (int i = 3; i >= 0; i--) begin
            if (m[i] && (i > int'(ch))) next_above = 2'(i);
        end
    endfunction

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        sel_d       = sel_q;
        mask_d      = mask_q;
        stop_pend_d = stop_pend_q;
        err_d       = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                sel_d = 2'd0;
                if (bus.start) begin
                    if (bus.ch_mask != 4'd0) begin
                        mask_d      = bus.ch_mask;
                        stop_pend_d = 1'b0;
                        sel_d       = lowest_ch(bus.ch_mask);
                        state_d     = RUN;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            RUN: begin
                if (bus.stop) stop_pend_d = 1'b1;

                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (has_above(mask_q, sel_q)) begin
                        sel_d = next_above(mask_q, sel_q);
                    end else if (bus.cont && !stop_pend_q && !bus.stop) begin
                        // Frame boundary in continuous mode: a stop arriving on this
                        // very cycle still ends scanning here.
                        if (bus.ch_mask != 4'd0) begin
                            mask_d = bus.ch_mask;
                            sel_d  = lowest_ch(bus.ch_mask);
                        end else begin
                            err_d   = 1'b1;
                            sel_d   = 2'd0;
                            state_d = IDLE;
                        end
                    end else begin
                        sel_d   = 2'd0;
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + CNT_ONE;
                end
            end

            default: begin
                state_d = IDLE;
                cnt_d   = '0;
                sel_d   = 2'd0;
            end
        endcase

        // Outputs are registered, so they are derived from the next-state values.
        busy_d = (state_d == RUN);
        y_d    = busy_d & bus.din;
        done_d = busy_d && (cnt_d == CNT_LAST) && !has_above(mask_d, sel_d);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            sel_q       <= 2'd0;
            mask_q      <= 4'd0;
            stop_pend_q <= 1'b0;
            y_q         <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sel_q       <= sel_d;
            mask_q      <= mask_d;
            stop_pend_q <= stop_pend_d;
            y_q         <= y_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign bus.s1         = sel_q[1];
    assign bus.s0         = sel_q[0];
    assign bus.y          = y_q;
    assign bus.busy       = busy_q;
    assign bus.frame_done = done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_demux_scan_sequencer.sv
// Self-checking bench for demux_scan_sequencer with a frame-level reference model.
// Latency: one observation per clock, sampled 1 time unit after the rising edge.
// No backpressure on the DUT; the bench drives inputs right after each sample.
module tb_demux_scan_sequencer;

    localparam int DW = 4;

    logic clk;
    logic rst;
    int   checks;
    int   fails;

    logic [1:0] exp_sel[$];
    logic       exp_done[$];

    demux_scan_sequencer_if bus ();

    demux_scan_sequencer #(.DWELL(DW), .CNT_W(8)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs as {s1,s0,busy,frame_done,y,err}.
    function automatic logic [5:0] obs();
        return {bus.s1, bus.s0, bus.busy, bus.frame_done, bus.y, bus.err};
    endfunction

    // Reference model: one frame visits each enabled channel in ascending order
    // for DW cycles; frame_done marks the final cycle of the highest channel.
    function automatic void append_frame(input logic [3:0] m);
        int hi;
        hi = -1;
        for (int c = 0; c < 4; c++) if (m[c]) hi = c;
        for (int c = 0; c < 4; c++) begin
            if (m[c]) begin
                for (int k = 0; k < DW; k++) begin
                    exp_sel.push_back(2'(c));
                    exp_done.push_back((c == hi) && (k == DW - 1));
                end
            end
        end
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [5:0] got;
        rst = 1'b1; bus.start = 1'b1; bus.din = 1'b1; bus.ch_mask = 4'hF;
        for (int i = 0; i < 2; i++) begin
            step();
            got = obs(); checks++;
            if (got !== 6'b0) begin
                fails++;
                $display("FAIL reset cyc%0d: got %b expected %b", i, got, 6'b0);
            end
        end
        rst = 1'b0; bus.start = 1'b0; bus.din = 1'b0;
        step();
        got = obs(); checks++;
        if (got !== 6'b0) begin
            fails++;
            $display("FAIL reset_idle: got %b expected %b", got, 6'b0);
        end
    endtask

    // Single frame with cont=0; start, stop, ch_mask and din are randomised
    // during the frame since none of them may disturb it.
    task automatic test_single_frame(input logic [3:0] m, input string name);
        logic [5:0] got, exp;
        logic       sent;
        exp_sel.delete(); exp_done.delete();
        append_frame(m);
        bus.cont = 1'b0; bus.stop = 1'b0; bus.ch_mask = m; bus.start = 1'b1;
        bus.din = 1'($urandom_range(0, 1)); sent = bus.din;
        step();
        for (int i = 0; i < exp_sel.size(); i++) begin
            exp = {exp_sel[i], 1'b1, exp_done[i], sent, 1'b0};
            got = obs(); checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL %s cyc%0d: got %b expected %b", name, i + 1, got, exp);
            end
            bus.din     = 1'($urandom_range(0, 1)); sent = bus.din;
            bus.start   = 1'($urandom_range(0, 1));
            bus.stop    = 1'($urandom_range(0, 1));
            bus.ch_mask = 4'($urandom_range(0, 15));
            step();
        end
        got = obs(); checks++;
        if (got !== 6'b0) begin
            fails++;
            $display("FAIL %s idle: got %b expected %b", name, got, 6'b0);
        end
        bus.start = 1'b0; bus.stop = 1'b0;
    endtask

    task automatic test_random_frames();
        logic [3:0] m;
        for (int n = 0; n < 6; n++) begin
            m = 4'($urandom_range(1, 15));
            test_single_frame(m, $sformatf("random_m%b", m));
        end
    endtask

    task automatic test_continuous();
        logic [5:0] got, exp;
        logic       sent;
        exp_sel.delete(); exp_done.delete();
        append_frame(4'b0011);
        append_frame(4'b0011);
        bus.cont = 1'b1; bus.stop = 1'b0; bus.ch_mask = 4'b0011; bus.start = 1'b1;
        bus.din = 1'($urandom_range(0, 1)); sent = bus.din;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < exp_sel.size(); i++) begin
            exp = {exp_sel[i], 1'b1, exp_done[i], sent, 1'b0};
            got = obs(); checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL continuous cyc%0d: got %b expected %b", i + 1, got, exp);
            end
            bus.din = 1'($urandom_range(0, 1)); sent = bus.din;
            // Mask must hold through the frame-1 boundary; afterwards it is ignored.
            if (i >= 8) bus.ch_mask = 4'($urandom_range(0, 15));
            bus.stop = (i == 10);
            step();
        end
        for (int i = 0; i < 2; i++) begin
            got = obs(); checks++;
            if (got !== 6'b0) begin
                fails++;
                $display("FAIL continuous_idle%0d: got %b expected %b", i, got, 6'b0);
            end
            step();
        end
        bus.cont = 1'b0; bus.stop = 1'b0;
    endtask

    task automatic test_err();
        logic [5:0] got, exp;
        logic       sent;
        bus.cont = 1'b0; bus.ch_mask = 4'b0000; bus.start = 1'b1;
        step();
        bus.start = 1'b0;
        got = obs(); checks++;
        if (got !== 6'b000001) begin
            fails++;
            $display("FAIL err_start: got %b expected %b", got, 6'b000001);
        end
        step();
        got = obs(); checks++;
        if (got !== 6'b0) begin
            fails++;
            $display("FAIL err_clear: got %b expected %b", got, 6'b0);
        end
        // Continuous frame whose mask empties mid-frame: error at the boundary.
        exp_sel.delete(); exp_done.delete();
        append_frame(4'b0001);
        bus.cont = 1'b1; bus.ch_mask = 4'b0001; bus.start = 1'b1;
        bus.din = 1'($urandom_range(0, 1)); sent = bus.din;
        step();
        bus.start = 1'b0;
        for (int i = 0; i < exp_sel.size(); i++) begin
            exp = {exp_sel[i], 1'b1, exp_done[i], sent, 1'b0};
            got = obs(); checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL err_cont cyc%0d: got %b expected %b", i + 1, got, exp);
            end
            bus.ch_mask = 4'b0000;
            bus.din = 1'($urandom_range(0, 1)); sent = bus.din;
            step();
        end
        got = obs(); checks++;
        if (got !== 6'b000001) begin
            fails++;
            $display("FAIL err_boundary: got %b expected %b", got, 6'b000001);
        end
        step();
        got = obs(); checks++;
        if (got !== 6'b0) begin
            fails++;
            $display("FAIL err_after: got %b expected %b", got, 6'b0);
        end
        bus.cont = 1'b0;
    endtask

    task automatic test_reset_mid_dwell();
        logic [5:0] got, exp;
        logic       sent;
        exp_sel.delete(); exp_done.delete();
        append_frame(4'b0111);
        bus.cont = 1'b0; bus.ch_mask = 4'b0111; bus.start = 1'b1;
        bus.din = 1'($urandom_range(0, 1)); sent = bus.din;
        step();
        bus.start = 1'b0;
        // Cycles 1..10: ch0 x4, ch1 x4, then two cycles into ch2.
        for (int i = 0; i < 10; i++) begin
            exp = {exp_sel[i], 1'b1, exp_done[i], sent, 1'b0};
            got = obs(); checks++;
            if (got !== exp) begin
                fails++;
                $display("FAIL mid_rst_pre cyc%0d: got %b expected %b", i + 1, got, exp);
            end
            bus.din = 1'($urandom_range(0, 1)); sent = bus.din;
            if (i < 9) step();
        end
        rst = 1'b1; bus.din = 1'b1; bus.start = 1'b1;
        step();
        got = obs(); checks++;
        if (got !== 6'b0) begin
            fails++;
            $display("FAIL mid_rst: got %b expected %b", got, 6'b0);
        end
        rst = 1'b0; bus.start = 1'b0;
        step();
        got = obs(); checks++;
        if (got !== 6'b0) begin
            fails++;
            $display("FAIL mid_rst_idle: got %b expected %b", got, 6'b0);
        end
        test_single_frame(4'b0110, "after_rst");
    endtask

    initial begin
        checks = 0; fails = 0;
        rst = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.cont = 1'b0;
        bus.ch_mask = 4'd0; bus.din = 1'b0;

        test_reset();
        test_single_frame(4'b1111, "full_mask");
        test_single_frame(4'b1010, "mask_1010");
        test_random_frames();
        test_continuous();
        test_err();
        test_reset_mid_dwell();

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
